// File: rtl/divider_seq16_pkg.sv
// Shared constants, FSM state encoding and helpers for the 16-bit sequential divider.
package divider_seq16_pkg;

   localparam int DIV_WIDTH  = 16;
   localparam int ITER_COUNT = 16;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
      return ~v + 16'd1;
   endfunction

endpackage

// File: rtl/divider_seq16_addsub17.sv
// 17-bit adder/subtractor used for the trial subtract; cout is borrow-not when sub=1.
module addsub17
   import divider_seq16_pkg::*;
(
   input  logic [DIV_WIDTH:0] a,
   input  logic [DIV_WIDTH:0] b,
   input  logic               sub,
   output logic [DIV_WIDTH:0] sum,
   output logic               cout
);

   logic [DIV_WIDTH+1:0] total;

   assign total = {1'b0, a} + {1'b0, b ^ {(DIV_WIDTH+1){sub}}} + {{(DIV_WIDTH+1){1'b0}}, sub};
   assign sum   = total[DIV_WIDTH:0];
   assign cout  = total[DIV_WIDTH+1];

endmodule

// File: rtl/divider_seq16.sv
// Sequential restoring divider, 16 bits, one quotient bit per cycle.
// Optional signed (truncating) mode enabled by defining DIVIDER_SIGNED_EN.
module divider_seq16
   import divider_seq16_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
   input  logic                 signed_op,
`endif
   output logic [DIV_WIDTH-1:0] quotient,
   output logic [DIV_WIDTH-1:0] remainder,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic                 overflow
);

   state_e               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] a_q, a_d;         // dividend shifting out, quotient shifting in
   logic [DIV_WIDTH-1:0] p_q, p_d;         // partial remainder
   logic [DIV_WIDTH-1:0] d_q, d_d;
   logic [DIV_WIDTH-1:0] quot_q, quot_d;
   logic [DIV_WIDTH-1:0] rem_q, rem_d;
   logic                 done_q, done_d;
   logic                 dz_q, dz_d;
   logic                 dz_out_q, dz_out_d;

   logic [DIV_WIDTH-1:0] mag_a, mag_b;
   logic [DIV_WIDTH:0]   trial_a, diff;
   logic                 no_borrow;

`ifdef DIVIDER_SIGNED_EN
   logic neg_a, neg_b, ovf_hit;
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;
   logic ovf_q, ovf_d;
   logic ovf_out_q, ovf_out_d;

   assign neg_a   = signed_op & dividend[DIV_WIDTH-1];
   assign neg_b   = signed_op & divisor[DIV_WIDTH-1];
   assign mag_a   = neg_a ? negate(dividend) : dividend;
   assign mag_b   = neg_b ? negate(divisor) : divisor;
   assign ovf_hit = neg_a & neg_b & (dividend == 16'h8000) & (divisor == 16'hFFFF);
`else
   assign mag_a = dividend;
   assign mag_b = divisor;
`endif

   assign trial_a = {p_q, a_q[DIV_WIDTH-1]};

   addsub17 u_trial (
      .a    (trial_a),
      .b    ({1'b0, d_q}),
      .sub  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      p_d      = p_q;
      d_d      = d_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      dz_out_d = dz_out_q;
`ifdef DIVIDER_SIGNED_EN
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      ovf_d     = ovf_q;
      ovf_out_d = ovf_out_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d = 5'd0;
               d_d   = mag_b;
               if (divisor == '0) begin
                  // Zero divisor skips RUN; the result is preloaded so DONE treats it uniformly.
                  state_d = ST_DONE;
                  a_d     = DIV_ZERO_QUOT;
                  p_d     = dividend;
                  dz_d    = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
                  ovf_d  = 1'b0;
`endif
               end else begin
                  state_d = ST_RUN;
                  a_d     = mag_a;
                  p_d     = '0;
                  dz_d    = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                  qneg_d = neg_a ^ neg_b;
                  rneg_d = neg_a;
                  ovf_d  = ovf_hit;
`endif
               end
            end
         end
         ST_RUN: begin
            a_d = {a_q[DIV_WIDTH-2:0], no_borrow};
            p_d = no_borrow ? diff[DIV_WIDTH-1:0] : trial_a[DIV_WIDTH-1:0];
            if (cnt_q == 5'(ITER_COUNT - 1)) begin
               state_d = ST_DONE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            dz_out_d = dz_q;
`ifdef DIVIDER_SIGNED_EN
            quot_d    = qneg_q ? negate(a_q) : a_q;
            rem_d     = rneg_q ? negate(p_q) : p_q;
            ovf_out_d = ovf_q;
`else
            quot_d = a_q;
            rem_d  = p_q;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         a_q      <= '0;
         p_q      <= '0;
         d_q      <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         dz_out_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         ovf_q     <= 1'b0;
         ovf_out_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         p_q      <= p_d;
         d_q      <= d_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         dz_out_q <= dz_out_d;
`ifdef DIVIDER_SIGNED_EN
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         ovf_q     <= ovf_d;
         ovf_out_q <= ovf_out_d;
`endif
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_by_zero = dz_out_q;
`ifdef DIVIDER_SIGNED_EN
   assign overflow = ovf_out_q;
`else
   assign overflow = 1'b0;
`endif

endmodule
